// File: rtl/regfile_tagged.sv
// ----------------------------------------------------------------------------
// regfile_tagged
//   Architectural register file for register renaming. Each of DEPTH entries
//   holds a data word, a busy bit (value still in flight) and the ROB tag of
//   the instruction that will produce it.
//
//   Ports
//     clk                 clock, all state updates on posedge
//     clr                 synchronous active-high reset, highest priority
//     flush               clear every busy bit (data/tags kept), blocks rename
//     rn_en/addr/tag      rename: mark destination busy with a new ROB tag
//     cm_en/addr/data/tag commit: write data, retire busy if tag still owns it
//     raddr0/1            combinational source read addresses
//     rdata0/1            source data (commit data bypassed in)
//     rbusy0/1            source still pending
//     rtag0/1             ROB tag producing the source (valid when busy)
// ----------------------------------------------------------------------------
module regfile_tagged #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int TAGW  = 3,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             rn_en,
    input  logic [AW-1:0]    rn_addr,
    input  logic [TAGW-1:0]  rn_tag,
    input  logic             cm_en,
    input  logic [AW-1:0]    cm_addr,
    input  logic [WIDTH-1:0] cm_data,
    input  logic [TAGW-1:0]  cm_tag,
    input  logic [AW-1:0]    raddr0,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic             rbusy0,
    output logic             rbusy1,
    output logic [TAGW-1:0]  rtag0,
    output logic [TAGW-1:0]  rtag1
);

    // Power-up value matches the reset value.
    logic [WIDTH-1:0] data_q [DEPTH] = '{default: '0};
    logic [TAGW-1:0]  tag_q  [DEPTH] = '{default: '0};
    logic [DEPTH-1:0] busy_q         = '0;

    logic [WIDTH-1:0] data_d [DEPTH];
    logic [TAGW-1:0]  tag_d  [DEPTH];
    logic [DEPTH-1:0] busy_d;

    // ------------------------------------------------------------------------
    // Per-entry next state
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic cm_hit;
        logic cm_own;
        logic rn_hit;

        assign cm_hit = cm_en & (cm_addr == AW'(g));
        // Commit only retires busy when its tag still owns the register;
        // otherwise a younger rename is outstanding.
        assign cm_own = cm_hit & busy_q[g] & (tag_q[g] == cm_tag);
        assign rn_hit = rn_en & (rn_addr == AW'(g));

        always_comb begin
            data_d[g] = data_q[g];
            tag_d[g]  = tag_q[g];
            busy_d[g] = busy_q[g];

            // Data write is unconditional on commit, even during flush.
            if (cm_hit)
                data_d[g] = cm_data;

            if (flush) begin
                busy_d[g] = 1'b0;
            end else begin
                if (cm_own)
                    busy_d[g] = 1'b0;
                // Rename is ordered after commit so it wins on a collision.
                if (rn_hit) begin
                    busy_d[g] = 1'b1;
                    tag_d[g]  = rn_tag;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (clr) begin
                data_q[g] <= '0;
                tag_q[g]  <= '0;
                busy_q[g] <= 1'b0;
            end else begin
                data_q[g] <= data_d[g];
                tag_q[g]  <= tag_d[g];
                busy_q[g] <= busy_d[g];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read ports: stored state (pre-rename) with same-cycle commit bypass.
    // ------------------------------------------------------------------------
    logic rd_cm0, rd_cm1;
    logic rd_own0, rd_own1;

    assign rd_cm0  = cm_en & (raddr0 == cm_addr);
    assign rd_cm1  = cm_en & (raddr1 == cm_addr);
    assign rd_own0 = rd_cm0 & busy_q[raddr0] & (tag_q[raddr0] == cm_tag);
    assign rd_own1 = rd_cm1 & busy_q[raddr1] & (tag_q[raddr1] == cm_tag);

    assign rdata0 = rd_cm0 ? cm_data : data_q[raddr0];
    assign rdata1 = rd_cm1 ? cm_data : data_q[raddr1];
    assign rbusy0 = busy_q[raddr0] & ~rd_own0;
    assign rbusy1 = busy_q[raddr1] & ~rd_own1;
    assign rtag0  = tag_q[raddr0];
    assign rtag1  = tag_q[raddr1];

endmodule
